// File: rtl/memShare_config_pkg.sv
// Shared configuration for the SCU.memShare() skid selector family.
package memShare_config_pkg;

  localparam int MAX_ALLOC_SEQ_NUM  = 2;
  localparam int SKID_DEPTH_DEFAULT = 2;
  localparam int SKID_LVL_W         = $clog2(SKID_DEPTH_DEFAULT + 1);

  typedef logic [SKID_LVL_W-1:0] skid_lvl_t;

  localparam skid_lvl_t SKID_LVL_NONE = skid_lvl_t'(0);
  localparam skid_lvl_t SKID_LVL_MAX  = skid_lvl_t'(SKID_DEPTH_DEFAULT);

endpackage

// File: rtl/memshare_skid_lane.sv
// One lane of the multi-depth skid selector: level, back-to-back run and sticky overflow.
// Build option MEMSHARE_SKID_REG_OUT_EN: drive the select from the level register instead of lvlNext.
module memshare_skid_lane
  import memShare_config_pkg::*;
#(
  parameter  int SKID_DEPTH = SKID_DEPTH_DEFAULT,
  parameter  int B2B_WIN    = MAX_ALLOC_SEQ_NUM + 1,
  localparam int LVL_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             busy,
  input  logic             pipeCycleBegin,
  input  logic             isGtr,
  output logic [LVL_W-1:0] skidLvl,
  output logic             skidOvf
);

  localparam int RUN_W = $clog2(B2B_WIN + 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(SKID_DEPTH);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(B2B_WIN);

  logic [LVL_W-1:0] lvlReg, lvlNext;
  logic [RUN_W-1:0] runReg, runNext;
  logic             ovfReg, ovfNext;
  logic             b2b, atMax;

  always_comb begin
    b2b   = (runReg == RUN_MAX);
    atMax = (lvlReg == LVL_MAX);

    // Priority chain: idle, first hit, back-to-back drain, pipeline start, climb, hold.
    lvlNext = lvlReg;
    if (!busy)
      lvlNext = '0;
    else if (isGtr && lvlReg == '0)
      lvlNext = LVL_W'(1);
    else if (b2b)
      lvlNext = '0;
    else if (isGtr && pipeCycleBegin)
      lvlNext = '0;
    else if (isGtr && lvlReg < LVL_MAX)
      lvlNext = lvlReg + LVL_W'(1);

    runNext = '0;
    if (busy && isGtr)
      runNext = b2b ? runReg : runReg + RUN_W'(1);

    ovfNext = 1'b0;
    if (busy)
      ovfNext = ovfReg | (isGtr & atMax & ~b2b & ~pipeCycleBegin);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      lvlReg <= '0;
      runReg <= '0;
      ovfReg <= 1'b0;
    end else begin
      lvlReg <= lvlNext;
      runReg <= runNext;
      ovfReg <= ovfNext;
    end
  end

`ifdef MEMSHARE_SKID_REG_OUT_EN
  assign skidLvl = lvlReg;
`else
  // Gate with rstn so an asserted reset forces the select low before the next edge.
  assign skidLvl = rstn ? lvlNext : '0;
`endif

  assign skidOvf = ovfReg;

endmodule

// File: rtl/memshare_skid_ctrl_mc.sv
// Multi-channel skid-buffer mux select for the SCU.memShare() lanes.
// Build option MEMSHARE_SKID_REG_OUT_EN: registered select with one cycle of latency.
module memshare_skid_ctrl_mc
  import memShare_config_pkg::*;
#(
  parameter  int CH_NUM     = 4,
  parameter  int SKID_DEPTH = SKID_DEPTH_DEFAULT,
  parameter  int B2B_WIN    = MAX_ALLOC_SEQ_NUM + 1,
  localparam int LVL_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic                    sys_clk,
  input  logic                    rstn,
  input  logic                    scu_memShare_busy_i,
  input  logic                    pipeCycle_begin_i,
  input  logic [CH_NUM-1:0]       isGtr_i,
  output logic [CH_NUM*LVL_W-1:0] skid_lvl_o,
  output logic                    skid_any_o,
  output logic [CH_NUM-1:0]       skid_ovf_o
);

  logic [CH_NUM-1:0] laneActive;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_lane
      logic [LVL_W-1:0] laneLvl;

      memshare_skid_lane #(
        .SKID_DEPTH(SKID_DEPTH),
        .B2B_WIN   (B2B_WIN)
      ) u_lane (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .busy          (scu_memShare_busy_i),
        .pipeCycleBegin(pipeCycle_begin_i),
        .isGtr         (isGtr_i[gi]),
        .skidLvl       (laneLvl),
        .skidOvf       (skid_ovf_o[gi])
      );

      assign skid_lvl_o[gi*LVL_W +: LVL_W] = laneLvl;
      assign laneActive[gi]                = |laneLvl;
    end
  endgenerate

  assign skid_any_o = |laneActive;

endmodule

// File: tb/tb_memshare_skid_ctrl_mc.sv
// Directed bench for memshare_skid_ctrl_mc (4 lanes, depth 2, back-to-back window 3).
// With MEMSHARE_SKID_REG_OUT_EN defined the select expectations shift by one cycle.
module tb_memshare_skid_ctrl_mc;

`ifdef MEMSHARE_SKID_REG_OUT_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic       sysClk = 1'b0;
  logic       rstn;
  logic       busy;
  logic       pipeBegin;
  logic [3:0] isGtr;
  logic [7:0] skidLvl;
  logic       skidAny;
  logic [3:0] skidOvf;

  int passCnt  = 0;
  int totalCnt = 0;
  logic [7:0] prevLvl = 8'h00;

  always #5 sysClk = ~sysClk;

  memshare_skid_ctrl_mc dut (
    .sys_clk            (sysClk),
    .rstn               (rstn),
    .scu_memShare_busy_i(busy),
    .pipeCycle_begin_i  (pipeBegin),
    .isGtr_i            (isGtr),
    .skid_lvl_o         (skidLvl),
    .skid_any_o         (skidAny),
    .skid_ovf_o         (skidOvf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a rising edge; lvl is the zero-latency expectation for this cycle.
  task automatic step(input string tag, input logic b, input logic p, input logic [3:0] g,
                      input logic [7:0] lvl, input logic [3:0] ovf);
    logic [7:0] expLvl;
    busy = b; pipeBegin = p; isGtr = g;
    expLvl = REG_OUT ? prevLvl : lvl;
    prevLvl = lvl;
    @(negedge sysClk);
    chk({tag, ".lvl"}, 32'(skidLvl), 32'(expLvl));
    chk({tag, ".any"}, 32'(skidAny), 32'(expLvl != 8'h00));
    chk({tag, ".ovf"}, 32'(skidOvf), 32'(ovf));
    $display("step %-8s busy=%0b pcb=%0b gtr=%h -> lvl=%h any=%0b ovf=%h",
             tag, b, p, g, skidLvl, skidAny, skidOvf);
    @(posedge sysClk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; busy = 1'b0; pipeBegin = 1'b0; isGtr = 4'h0;
    repeat (3) begin
      @(negedge sysClk);
      chk("rst.lvl", 32'(skidLvl), 32'h0);
      chk("rst.any", 32'(skidAny), 32'h0);
      chk("rst.ovf", 32'(skidOvf), 32'h0);
    end
    @(posedge sysClk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 5; i++) step("idle", 1'b0, 1'b0, 4'hF, 8'h00, 4'h0);

    // Lane 0 ramp: pulses on cycles 0, 2, 4.
    step("ramp0", 1'b1, 1'b0, 4'h1, 8'h01, 4'h0);
    step("ramp1", 1'b1, 1'b0, 4'h0, 8'h01, 4'h0);
    step("ramp2", 1'b1, 1'b0, 4'h1, 8'h02, 4'h0);
    step("ramp3", 1'b1, 1'b0, 4'h0, 8'h02, 4'h0);
    step("ramp4", 1'b1, 1'b0, 4'h1, 8'h02, 4'h0);
    step("ramp5", 1'b1, 1'b0, 4'h0, 8'h02, 4'h1);
    step("clr0",  1'b0, 1'b0, 4'h0, 8'h00, 4'h1);

    // Lane 1 back-to-back drain.
    step("b2b0", 1'b1, 1'b0, 4'h2, 8'h04, 4'h0);
    step("b2b1", 1'b1, 1'b0, 4'h2, 8'h08, 4'h0);
    step("b2b2", 1'b1, 1'b0, 4'h2, 8'h08, 4'h0);
    step("b2b3", 1'b1, 1'b0, 4'h2, 8'h00, 4'h2);
    step("b2b4", 1'b1, 1'b0, 4'h2, 8'h04, 4'h2);
    step("clr1", 1'b0, 1'b0, 4'h0, 8'h00, 4'h2);

    // Lane 2 pipeline-begin clear versus first hit.
    step("pcb0", 1'b1, 1'b0, 4'h4, 8'h10, 4'h0);
    step("pcb1", 1'b1, 1'b1, 4'h4, 8'h00, 4'h0);
    step("pcb2", 1'b1, 1'b1, 4'h4, 8'h10, 4'h0);
    step("clr2", 1'b0, 1'b0, 4'h0, 8'h00, 4'h0);

    // Lane 3 overflow, then busy drop.
    step("ovf0", 1'b1, 1'b0, 4'h8, 8'h40, 4'h0);
    step("ovf1", 1'b1, 1'b0, 4'h8, 8'h80, 4'h0);
    step("ovf2", 1'b1, 1'b0, 4'h0, 8'h80, 4'h0);
    step("ovf3", 1'b1, 1'b0, 4'h8, 8'h80, 4'h0);
    step("ovf4", 1'b1, 1'b0, 4'h0, 8'h80, 4'h8);
    step("drop0", 1'b0, 1'b0, 4'h8, 8'h00, 4'h8);
    step("drop1", 1'b0, 1'b0, 4'h0, 8'h00, 4'h0);

    // Rebuild lane 3 at level 2 with overflow, then reset mid-cycle.
    step("re0", 1'b1, 1'b0, 4'h8, 8'h40, 4'h0);
    step("re1", 1'b1, 1'b0, 4'h8, 8'h80, 4'h0);
    step("re2", 1'b1, 1'b0, 4'h0, 8'h80, 4'h0);
    step("re3", 1'b1, 1'b0, 4'h8, 8'h80, 4'h0);
    busy = 1'b1; pipeBegin = 1'b0; isGtr = 4'h8;
    #1;
    chk("arst.pre.lvl", 32'(skidLvl), 32'h80);
    chk("arst.pre.ovf", 32'(skidOvf), 32'h8);
    #1 rstn = 1'b0;
    #1;
    chk("arst.lvl", 32'(skidLvl), 32'h0);
    chk("arst.any", 32'(skidAny), 32'h0);
    chk("arst.ovf", 32'(skidOvf), 32'h0);
    $display("step arst     lvl=%h any=%0b ovf=%h", skidLvl, skidAny, skidOvf);
    @(posedge sysClk);
    #1 rstn = 1'b1;
    prevLvl = 8'h00;
    step("post0", 1'b1, 1'b0, 4'h1, 8'h01, 4'h0);
    step("post1", 1'b0, 1'b0, 4'h0, 8'h00, 4'h0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/memshare_skid_ctrl_mc.md
Name: memshare_skid_ctrl_mc

Overview:
- Multi-channel, multi-depth successor of the single-lane SCU.memShare() skid selector.
- Per channel, tracks how many skid-buffer stages the column-address path must bypass: 0..SKID_DEPTH instead of a 1-bit skid/no-skid.
- Drives the skid-buffer multiplexer select of each SCU.memShare() lane.
- Adds a saturating back-to-back isGtr run counter and a sticky per-channel overflow flag.

Parameters:
- CH_NUM, 4: number of independent lanes.
- SKID_DEPTH, 2: maximum skid level per lane (≥1).
- B2B_WIN, MAX_ALLOC_SEQ_NUM+1: consecutive registered isGtr cycles that force a drain to level 0.
- LVL_W, $clog2(SKID_DEPTH+1): width of the level select (derived; do not override).

Ports:
- sys_clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- scu_memShare_busy_i  in  1  high throughout the SCU.memShare() operation; shared by all lanes.
- pipeCycle_begin_i  in  1  first cycle of a memShare pipeline cycle; shared by all lanes.
- isGtr_i  in  CH_NUM  per-lane isGtr from RFMU (SHIFT_GEN state).
- skid_lvl_o  out  CH_NUM*LVL_W  per-lane skid mux select; lane c occupies bits [c*LVL_W +: LVL_W].
- skid_any_o  out  1  OR over lanes of (skid_lvl_o != 0).
- skid_ovf_o  out  CH_NUM  sticky per-lane overflow.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is asynchronous and active-low on rstn.
- Reset values: all lane level registers = 0, run counters = 0, skid_ovf_o = 0. Therefore skid_lvl_o = 0 and skid_any_o = 0.
- Per-lane registered state:
  - lvl_q (LVL_W bits).
  - run_q, saturating, range 0..B2B_WIN.
  - ovf_q.
- Back-to-back detect: b2b = (run_q == B2B_WIN). run_q counts consecutive registered isGtr samples and excludes the current input.
- Next-level lvl_d, evaluated in strict priority order:
  1. !busy → 0. Also clears run_q and ovf_q next cycle (prevents X propagation outside the operation).
  2. isGtr & lvl_q==0 → 1.
  3. b2b → 0.
  4. isGtr & pipeCycle_begin_i → 0.
  5. isGtr & lvl_q<SKID_DEPTH → lvl_q+1.
  6. Otherwise hold lvl_q.
- lvl_q <= lvl_d every cycle.
- run_q next value:
  - 0 if !busy or !isGtr.
  - min(run_q+1, B2B_WIN) otherwise.
- Overflow: ovf_q set when busy & isGtr & lvl_q==SKID_DEPTH and rules 3 and 4 do not fire; level holds at SKID_DEPTH. ovf_q stays set until busy deasserts.
- Output timing (default build): skid_lvl_o = lvl_d, combinational, zero latency from isGtr_i. skid_any_o is derived from the same value.
- Lane independence: lanes share only busy and pipeCycle_begin_i; no cross-lane coupling.
- Reset mid-operation: the asynchronous clear overrides everything, and outputs return to 0 immediately.
- busy falling while lvl_q>0: output goes to 0 in the same cycle (rule 1).

Optional Feature:
- Macro MEMSHARE_SKID_REG_OUT_EN.
- Defined: skid_lvl_o = lvl_q and skid_any_o is registered, giving 1-cycle latency. Intended for timing closure when the mux sits in a distant SLR.
- Undefined: combinational output as specified above.
- skid_ovf_o is registered in both builds.

Decomposition:
- memShare_config_pkg additions:
  - MAX_ALLOC_SEQ_NUM (existing).
  - SKID_DEPTH_DEFAULT.
  - typedef skid_lvl_t, logic [LVL_W-1:0].
  - localparams SKID_LVL_NONE = 0 and SKID_LVL_MAX.
- Sub-module memshare_skid_lane: one lane's lvl/run/ovf logic, instantiated CH_NUM times in a generate loop.
- The top level contains only the generate loop, the output packing and the skid_any_o OR-reduction.

Test Plan:
- Reset and idle: hold rstn=0 for 3 cycles, then busy=0 with isGtr=4'hF for 5 cycles → skid_lvl_o=0, skid_ovf_o=0, skid_any_o=0 throughout.
- Level ramp, lane 0, busy=1, pipeCycle_begin=0: isGtr[0] pulses on cycles 0, 2, 4 with low between → output 1, 1, 2, 2, 2; run_q never reaches B2B_WIN=3.
- Back-to-back drain, lane 1: isGtr[1]=1 for 5 consecutive cycles → output 1, 2, 2 (ovf set at cycle 2), then 0 at cycle 3 once run_q=3; other lanes stay 0.
- Pipeline-begin clear, lane 2 at lvl 1: isGtr=1 with pipeCycle_begin=1 → output 0 that cycle. The same stimulus at lvl 0 → output 1 (rule 2 beats rule 4).
- busy drop and async reset: lane 3 at lvl 2 with ovf=1, then busy→0 → output 0 the same cycle and ovf clears next cycle. Asserting rstn low mid-cycle → all outputs 0 before the next sys_clk edge.
- MEMSHARE_SKID_REG_OUT_EN build: rerun the ramp scenario → identical sequence delayed by exactly 1 cycle.
